// File: rtl/servo_cmd_input_pkg.sv
// Shared definitions for the servo command front end: debounce state encoding,
// tick rate and a counter-width helper.
package servo_pkg;

    localparam int CLK_TICK_HZ = 10000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM_P = 2'd1,
        HELD  = 2'd2,
        ARM_R = 2'd3
    } deb_state_t;

    // One spare bit above the width needed for the largest count.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count) + 1;
    endfunction

endpackage

// File: rtl/servo_cmd_input_if.sv
// Button inputs and servo/display outputs of the command front end.
interface servo_cmd_input_if;

    logic       btn_vel;
    logic       btn_en;
    logic       vel;
    logic       enable;
    logic [2:0] speed_level;
    logic       vel_held;

    modport master (
        output btn_vel,
        output btn_en,
        input  vel,
        input  enable,
        input  speed_level,
        input  vel_held
    );

    modport slave (
        input  btn_vel,
        input  btn_en,
        output vel,
        output enable,
        output speed_level,
        output vel_held
    );

endinterface

// File: rtl/servo_cmd_input_btn_debounce.sv
// Synchroniser plus debounce FSM for one raw push-button. Emits a one-cycle
// press strobe on an accepted press; releases are accepted silently.
module btn_debounce
    import servo_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_TICKS = 200
) (
    input  logic       clk_10KHz,
    input  logic       reset,
    input  logic       raw,
    output logic       press,
    output logic       held,
    output deb_state_t state
);

    localparam int             CW    = cnt_width(DEBOUNCE_TICKS);
    localparam logic [CW-1:0]  TICKS = CW'(DEBOUNCE_TICKS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    deb_state_t             state_q;
    deb_state_t             state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A level must survive DEBOUNCE_TICKS consecutive cycles; any reversal
    // drops back to the previous stable state with the counter cleared.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = ARM_P;
                    cnt_d   = CW'(1);
                end
            end
            ARM_P: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == TICKS) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = ARM_R;
                    cnt_d   = CW'(1);
                end
            end
            ARM_R: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == TICKS) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        press = (state_q == ARM_P) && s && (cnt_q == TICKS);
        held  = (state_q == HELD) || (state_q == ARM_R);
        state = state_q;
    end

endmodule

// File: rtl/servo_cmd_input.sv
// Servo command front end: debounced speed button with auto-repeat, enable
// toggle, and a 3-bit shadow of the accepted speed steps.
module servo_cmd_input
    import servo_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_TICKS = 200,
    parameter int REPEAT_DELAY   = 5000,
    parameter int REPEAT_PERIOD  = 2500
) (
    input  logic                clk_10KHz,
    input  logic                reset,
    servo_cmd_input_if.slave    bus
);

    localparam int            HW     = cnt_width(REPEAT_DELAY);
    localparam int            PW     = cnt_width(REPEAT_PERIOD);
    localparam logic [HW-1:0] DELAY  = HW'(REPEAT_DELAY);
    localparam logic [PW-1:0] PERIOD = PW'(REPEAT_PERIOD - 1);

    logic       vel_press;
    logic       vel_held;
    deb_state_t vel_state;
    logic       en_press;
    logic       en_held;
    deb_state_t en_state;
    logic       en_unused;

    logic [HW-1:0] hold_q;
    logic [PW-1:0] per_q;
    logic          repeat_hit;
    logic          step_d;
    logic          vel_q;
    logic          enable_q;
    logic [2:0]    speed_q;

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_vel_deb (
        .clk_10KHz (clk_10KHz),
        .reset     (reset),
        .raw       (bus.btn_vel),
        .press     (vel_press),
        .held      (vel_held),
        .state     (vel_state)
    );

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_en_deb (
        .clk_10KHz (clk_10KHz),
        .reset     (reset),
        .raw       (bus.btn_en),
        .press     (en_press),
        .held      (en_held),
        .state     (en_state)
    );

    assign en_unused = en_held ^ (en_state == ARM_R);

    // The hold counter starts at 1 on the press edge so the first repeat lands
    // exactly REPEAT_DELAY cycles after the press pulse. Once it saturates at
    // REPEAT_DELAY the period counter takes over; ARM_R freezes both.
    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            per_q  <= '0;
        end else if (vel_press) begin
            hold_q <= HW'(1);
            per_q  <= '0;
        end else if (vel_state == HELD) begin
            if (hold_q != DELAY) begin
                hold_q <= hold_q + 1'b1;
            end else if (per_q == PERIOD) begin
                per_q <= '0;
            end else begin
                per_q <= per_q + 1'b1;
            end
        end else if (vel_state != ARM_R) begin
            hold_q <= '0;
            per_q  <= '0;
        end
    end

    assign repeat_hit = (vel_state == HELD) && (hold_q == DELAY) && (per_q == '0);
    assign step_d     = (vel_press || repeat_hit) && !vel_q;

    // speed_level samples the enable value from before any same-cycle toggle.
    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            vel_q    <= 1'b0;
            enable_q <= 1'b0;
            speed_q  <= '0;
        end else begin
            vel_q    <= step_d;
            enable_q <= enable_q ^ en_press;
            speed_q  <= speed_q + 3'(step_d && enable_q);
        end
    end

    assign bus.vel         = vel_q;
    assign bus.enable      = enable_q;
    assign bus.speed_level = speed_q;
    assign bus.vel_held    = vel_held;

endmodule

// File: tb/tb_servo_cmd_input.sv
// Directed self-checking bench for servo_cmd_input with default parameters.
`timescale 1us/1ns
module tb_servo_cmd_input;

    logic clk_10KHz = 1'b0;
    logic reset     = 1'b1;

    servo_cmd_input_if bus ();

    servo_cmd_input dut (
        .clk_10KHz (clk_10KHz),
        .reset     (reset),
        .bus       (bus)
    );

    always #50 clk_10KHz = ~clk_10KHz;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int base     = 0;
    int pulses[$];
    bit held_seen = 1'b0;
    int en_rise  = -1;
    bit en_prev  = 1'b0;

    always @(posedge clk_10KHz) cyc <= cyc + 1;

    // Pulse cycles are recorded relative to the cycle the current window opened.
    always @(negedge clk_10KHz) begin
        if (bus.vel) pulses.push_back(cyc - base);
        if (bus.vel_held) held_seen = 1'b1;
        if (bus.enable && !en_prev) en_rise = cyc - base;
        en_prev = bus.enable;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic openWindow();
        base      = cyc;
        pulses.delete();
        held_seen = 1'b0;
        en_rise   = -1;
    endtask

    task automatic applyStimulus(input logic v, input logic e, input int n);
        bus.btn_vel = v;
        bus.btn_en  = e;
        repeat (n) @(negedge clk_10KHz);
    endtask

    task automatic pressRelease(input logic v, input logic e);
        applyStimulus(v, e, 300);
        applyStimulus(1'b0, 1'b0, 300);
    endtask

    function automatic int pulseAt(input int i);
        return (i < pulses.size()) ? pulses[i] : -1;
    endfunction

    int t3_exp[4] = '{203, 5203, 7703, 10203};

    initial begin
        bus.btn_vel = 1'b0;
        bus.btn_en  = 1'b0;
        repeat (3) @(negedge clk_10KHz);
        checkOutput("rst_vel", int'(bus.vel), 0);
        checkOutput("rst_enable", int'(bus.enable), 0);
        checkOutput("rst_speed", int'(bus.speed_level), 0);
        checkOutput("rst_held", int'(bus.vel_held), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk_10KHz);

        // Enable toggles 0->1->0, then a speed press while disabled.
        openWindow();
        pressRelease(1'b0, 1'b1);
        checkOutput("t4_en_on", int'(bus.enable), 1);
        pressRelease(1'b0, 1'b1);
        checkOutput("t4_en_off", int'(bus.enable), 0);
        checkOutput("t4_no_vel", pulses.size(), 0);
        pressRelease(1'b1, 1'b0);
        checkOutput("t4_dis_pulses", pulses.size(), 1);
        checkOutput("t4_dis_speed", int'(bus.speed_level), 0);

        pressRelease(1'b0, 1'b1);
        checkOutput("en_on", int'(bus.enable), 1);

        // Single press with latency measurement.
        openWindow();
        applyStimulus(1'b1, 1'b0, 1000);
        checkOutput("t1_count", pulses.size(), 1);
        checkOutput("t1_cycle", pulseAt(0), 203);
        checkOutput("t1_speed", int'(bus.speed_level), 1);
        checkOutput("t1_held", int'(bus.vel_held), 1);
        applyStimulus(1'b0, 1'b0, 300);
        checkOutput("t1_released", int'(bus.vel_held), 0);

        // Bounce shorter than the debounce window.
        openWindow();
        for (int i = 0; i < 5; i++) applyStimulus(((i % 2) == 0), 1'b0, 30);
        applyStimulus(1'b0, 1'b0, 300);
        checkOutput("t2_pulses", pulses.size(), 0);
        checkOutput("t2_speed", int'(bus.speed_level), 1);
        checkOutput("t2_held", int'(held_seen), 0);

        // Long hold with auto-repeat.
        openWindow();
        applyStimulus(1'b1, 1'b0, 12000);
        checkOutput("t3_count", pulses.size(), 4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("t3_p%0d", i), pulseAt(i), t3_exp[i]);
        checkOutput("t3_speed", int'(bus.speed_level), 5);
        applyStimulus(1'b0, 1'b0, 300);

        // Three more steps reach eight and wrap.
        pressRelease(1'b1, 1'b0);
        checkOutput("wrap_6", int'(bus.speed_level), 6);
        pressRelease(1'b1, 1'b0);
        checkOutput("wrap_7", int'(bus.speed_level), 7);
        pressRelease(1'b1, 1'b0);
        checkOutput("wrap_0", int'(bus.speed_level), 0);

        // Both buttons together while disabled.
        pressRelease(1'b0, 1'b1);
        checkOutput("t5_pre_en", int'(bus.enable), 0);
        openWindow();
        applyStimulus(1'b1, 1'b1, 400);
        checkOutput("t5_vel_cycle", pulseAt(0), 203);
        checkOutput("t5_en_cycle", en_rise, 203);
        checkOutput("t5_enable", int'(bus.enable), 1);
        checkOutput("t5_speed", int'(bus.speed_level), 0);
        applyStimulus(1'b0, 1'b0, 300);

        pressRelease(1'b1, 1'b0);
        checkOutput("t6_pre_speed", int'(bus.speed_level), 1);

        // Reset in the middle of a press, button still held afterwards.
        openWindow();
        applyStimulus(1'b1, 1'b0, 100);
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_vel", int'(bus.vel), 0);
        checkOutput("t6_rst_enable", int'(bus.enable), 0);
        checkOutput("t6_rst_speed", int'(bus.speed_level), 0);
        checkOutput("t6_rst_held", int'(bus.vel_held), 0);
        repeat (3) @(negedge clk_10KHz);
        reset = 1'b0;
        openWindow();
        applyStimulus(1'b1, 1'b0, 400);
        checkOutput("t6_count", pulses.size(), 1);
        checkOutput("t6_cycle", pulseAt(0), 203);
        checkOutput("t6_speed", int'(bus.speed_level), 0);
        applyStimulus(1'b0, 1'b0, 300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
